// File: rtl/cache_2way_wb.sv
// cache_2way_wb
//   Two-way set-associative data cache (write-back, write-allocate, LRU)
//   in front of an internal 1 KiB byte-addressed main memory. It serves
//   32-bit word reads and writes once the TLB flags a physical address.
//
//   Address split: tag[9:5] | set[4] | word[3:2] | byte[1:0] (byte ignored).
//
//   Ports:
//     clk            in   clock, all state updates on the rising edge
//     reset          in   synchronous active-high reset
//     cpu_write      in   1 = write request, 0 = read request
//     cpu_address    in   byte address (word-aligned use)
//     cpu_write_data in   write data
//     tlb_end        in   request valid (address is physical)
//     cpu_read_data  out  registered read result, held until the next read
//     cpu_hit        out  registered hit/miss of the last accepted lookup
//     cpu_done       out  one-cycle completion pulse
//     cpu_ready      out  block can accept a request
//
//   Optional build macro: CACHE_WRITE_THROUGH_EN
//     defined   : every write also updates the 4 memory bytes in the DONE
//                 cycle; lines never become dirty, so WB is never entered.
//     undefined : write-back, memory changes only on dirty eviction.

// Byte-wide backing store with a whole-block write port (eviction), a word
// write port (write-through) and a combinational whole-block read port.
module main_memory #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BLK_BYTES = 16
) (
    input  logic                                clk,
    input  logic [ADDR_W-$clog2(BLK_BYTES)-1:0] blk_addr,
    output logic [8*BLK_BYTES-1:0]              blk_rdata,
    input  logic                                blk_we,
    input  logic [ADDR_W-$clog2(BLK_BYTES)-1:0] blk_waddr,
    input  logic [8*BLK_BYTES-1:0]              blk_wdata,
    input  logic                                word_we,
    input  logic [ADDR_W-3:0]                   word_addr,
    input  logic [31:0]                         word_wdata
);
    localparam int unsigned OFF_W = $clog2(BLK_BYTES);

    // Contents start at zero and are deliberately untouched by reset.
    logic [7:0] memory [0:(1<<ADDR_W)-1] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (blk_we) begin
            for (int unsigned i = 0; i < BLK_BYTES; i++) begin
                memory[{blk_waddr, OFF_W'(i)}] <= blk_wdata[8*i +: 8];
            end
        end
        if (word_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                memory[{word_addr, 2'(i)}] <= word_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        blk_rdata = '0;
        for (int unsigned i = 0; i < BLK_BYTES; i++) begin
            blk_rdata[8*i +: 8] = memory[{blk_addr, OFF_W'(i)}];
        end
    end
endmodule

module cache_2way_wb #(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned NUM_SETS        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_write_data,
    input  logic              tlb_end,
    output logic [31:0]       cpu_read_data,
    output logic              cpu_hit,
    output logic              cpu_done,
    output logic              cpu_ready
);
    localparam int unsigned WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned SET_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - SET_W;
    localparam int unsigned BLK_W  = 32 * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_DONE} state_t;

    state_t state, state_nx;

    logic             valid_q [NUM_SETS][2];
    logic             dirty_q [NUM_SETS][2];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][2];
    logic [BLK_W-1:0] line_q  [NUM_SETS][2];
    logic             lru_q   [NUM_SETS];
    logic             way_q;

    logic [TAG_W-1:0]  addr_tag;
    logic [SET_W-1:0]  addr_set;
    logic [WORD_W-1:0] addr_word;
    logic              unused_byte_sel;

    logic             hit_w0, hit_w1, hit, hit_way;
    logic             victim_way, victim_dirty;
    logic             accept;
    logic [BLK_W-1:0] mem_blk_rdata;
    logic             mem_word_we;

    assign addr_tag        = cpu_address[ADDR_W-1 -: TAG_W];
    assign addr_set        = cpu_address[OFF_W +: SET_W];
    assign addr_word       = cpu_address[2 +: WORD_W];
    assign unused_byte_sel = ^cpu_address[1:0];

    always_comb begin
        hit_w0       = valid_q[addr_set][0] && (tag_q[addr_set][0] == addr_tag);
        hit_w1       = valid_q[addr_set][1] && (tag_q[addr_set][1] == addr_tag);
        hit          = hit_w0 || hit_w1;
        hit_way      = hit_w1;
        victim_way   = !valid_q[addr_set][0] ? 1'b0 :
                       !valid_q[addr_set][1] ? 1'b1 : lru_q[addr_set];
        victim_dirty = valid_q[addr_set][victim_way] && dirty_q[addr_set][victim_way];
    end

    // The done cycle already sits in IDLE; holding off acceptance there keeps
    // a requester that still shows tlb_end from re-issuing the same access.
    assign accept    = (state == S_IDLE) && tlb_end && !cpu_done;
    assign cpu_ready = (state == S_IDLE) && !cpu_done;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hit)               state_nx = S_DONE;
                    else if (victim_dirty) state_nx = S_WB;
                    else                   state_nx = S_REFILL;
                end
            end
            S_WB:     state_nx = S_REFILL;
            S_REFILL: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_read_data <= '0;
            cpu_hit       <= 1'b0;
            cpu_done      <= 1'b0;
            way_q         <= 1'b0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int unsigned w = 0; w < 2; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            cpu_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cpu_hit <= hit;
                        way_q   <= hit ? hit_way : victim_way;
                    end
                end
                S_REFILL: begin
                    line_q[addr_set][way_q]  <= mem_blk_rdata;
                    tag_q[addr_set][way_q]   <= addr_tag;
                    valid_q[addr_set][way_q] <= 1'b1;
                    dirty_q[addr_set][way_q] <= 1'b0;
                end
                S_DONE: begin
                    if (cpu_write) begin
                        line_q[addr_set][way_q][32*addr_word +: 32] <= cpu_write_data;
`ifndef CACHE_WRITE_THROUGH_EN
                        dirty_q[addr_set][way_q] <= 1'b1;
`endif
                    end else begin
                        cpu_read_data <= line_q[addr_set][way_q][32*addr_word +: 32];
                    end
                    lru_q[addr_set] <= ~way_q;
                    cpu_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_WRITE_THROUGH_EN
    assign mem_word_we = (state == S_DONE) && cpu_write && !reset;
`else
    assign mem_word_we = 1'b0;
`endif

    main_memory #(
        .ADDR_W    (ADDR_W),
        .BLK_BYTES (4 * WORDS_PER_BLOCK)
    ) mainMemory (
        .clk        (clk),
        .blk_addr   ({addr_tag, addr_set}),
        .blk_rdata  (mem_blk_rdata),
        .blk_we     ((state == S_WB) && !reset),
        .blk_waddr  ({tag_q[addr_set][way_q], addr_set}),
        .blk_wdata  (line_q[addr_set][way_q]),
        .word_we    (mem_word_we),
        .word_addr  (cpu_address[ADDR_W-1:2]),
        .word_wdata (cpu_write_data)
    );
endmodule

// File: tb/tb_cache_2way_wb.sv
module tb_cache_2way_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_write;
    logic [9:0]  cpu_address;
    logic [31:0] cpu_write_data;
    logic        tlb_end;
    logic [31:0] cpu_read_data;
    logic        cpu_hit;
    logic        cpu_done;
    logic        cpu_ready;

    int compared   = 0;
    int mismatched = 0;

    cache_2way_wb #(
        .ADDR_W          (10),
        .WORDS_PER_BLOCK (4),
        .NUM_SETS        (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .tlb_end        (tlb_end),
        .cpu_read_data  (cpu_read_data),
        .cpu_hit        (cpu_hit),
        .cpu_done       (cpu_done),
        .cpu_ready      (cpu_ready)
    );

    always #5 clk = ~clk;

    // Reference model: memory as a byte array; the cache as a list of
    // resident blocks ordered oldest-use first (at most two per set).
    typedef struct packed {
        logic [4:0]   tag;
        logic         set;
        logic         dirty;
        logic [127:0] data;
    } mblk_t;

    mblk_t       resident [$];
    logic [7:0]  mem_m [0:1023];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_mem(input int a);
        check($sformatf("mem[%0d]", a), {24'h0, dut.mainMemory.memory[a]}, {24'h0, mem_m[a]});
    endtask

    task automatic model_access(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                                output logic exp_hit, output int exp_lat, output logic [31:0] exp_rd);
        logic [4:0] t = a[9:5];
        logic       s = a[4];
        int         w = int'(a[3:2]);
        int         idx = -1;
        int         oldest = -1;
        int         cnt = 0;
        mblk_t      b;
        for (int i = 0; i < resident.size(); i++) begin
            if (resident[i].set == s) begin
                cnt++;
                if (oldest < 0) oldest = i;
                if (resident[i].tag == t) idx = i;
            end
        end
        exp_hit = (idx >= 0);
        if (idx >= 0) begin
            b = resident[idx];
            resident.delete(idx);
            exp_lat = 1;
        end else begin
            exp_lat = 2;
            if (cnt == 2) begin
                b = resident[oldest];
                resident.delete(oldest);
                if (b.dirty) begin
                    exp_lat = 3;
                    for (int k = 0; k < 16; k++) mem_m[{b.tag, b.set, 4'(k)}] = b.data[8*k +: 8];
                end
            end
            b.tag   = t;
            b.set   = s;
            b.dirty = 1'b0;
            for (int k = 0; k < 16; k++) b.data[8*k +: 8] = mem_m[{t, s, 4'(k)}];
        end
        if (wr) begin
            b.data[32*w +: 32] = wd;
`ifdef CACHE_WRITE_THROUGH_EN
            for (int k = 0; k < 4; k++) mem_m[{a[9:2], 2'(k)}] = wd[8*k +: 8];
`else
            b.dirty = 1'b1;
`endif
            exp_rd = last_rd;
        end else begin
            exp_rd = b.data[32*w +: 32];
        end
        resident.push_back(b);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tlb_end = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        resident.delete();
        last_rd = '0;
    endtask

    task automatic do_access(input logic wr, input logic [9:0] a, input logic [31:0] wd);
        logic        eh;
        int          el;
        logic [31:0] er;
        int          n;
        int          waitc;
        bit          got;
        model_access(wr, a, wd, eh, el, er);
        waitc = 0;
        @(negedge clk);
        while (!cpu_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_req", {31'h0, cpu_ready}, 32'h1);
        cpu_write      = wr;
        cpu_address    = a;
        cpu_write_data = wd;
        tlb_end        = 1'b1;
        @(posedge clk);
        #1 tlb_end = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_done) got = 1'b1;
        end
        check($sformatf("latency %s @%h", wr ? "wr" : "rd", a), got ? n : 32'hFF, el);
        check($sformatf("hit @%h", a), {31'h0, cpu_hit}, {31'h0, eh});
        check($sformatf("read_data @%h", a), cpu_read_data, er);
        @(posedge clk);
        #1 check("done_pulse_width", {31'h0, cpu_done}, 32'h0);
        last_rd = er;
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
        cpu_write      = 1'b0;
        cpu_address    = '0;
        cpu_write_data = '0;
        do_reset();

        check("reset cpu_read_data", cpu_read_data, 32'h0);
        check("reset cpu_hit", {31'h0, cpu_hit}, 32'h0);
        check("reset cpu_done", {31'h0, cpu_done}, 32'h0);
        check("reset cpu_ready", {31'h0, cpu_ready}, 32'h1);

        // Directed sequence on set 0
        do_access(1'b0, 10'h000, 32'h0);
        do_access(1'b1, 10'h000, 32'h000000FF);
        do_access(1'b0, 10'h000, 32'h0);
        check_mem(0);
        do_access(1'b0, 10'h200, 32'h0);
        do_access(1'b0, 10'h000, 32'h0);
        do_access(1'b0, 10'h300, 32'h0);
        check_mem(0);
        do_access(1'b0, 10'h200, 32'h0);
        check_mem(0);
        check_mem(1);

        // Reset during the refill of a clean miss
        @(negedge clk);
        cpu_write   = 1'b0;
        cpu_address = 10'h100;
        tlb_end     = 1'b1;
        @(posedge clk);
        #1 tlb_end = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort cpu_done", {31'h0, cpu_done}, 32'h0);
        check("abort cpu_ready", {31'h0, cpu_ready}, 32'h1);
        check("abort cpu_read_data", cpu_read_data, 32'h0);
        nd = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (cpu_done) nd++;
        end
        check("abort no late done", nd, 0);
        resident.delete();
        last_rd = '0;
        do_access(1'b0, 10'h100, 32'h0);

        // Randomized traffic over a few conflicting tags
        for (int i = 0; i < 250; i++) begin
            logic [9:0]  a;
            logic [4:0]  t;
            t = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            a = {t, 1'($urandom), 2'($urandom), 2'($urandom)};
            do_access(1'($urandom), a, $urandom);
        end

        for (int i = 0; i < 1024; i++) check_mem(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
